// File: rtl/redma_pkg.sv
// Shared definitions for the copy-engine datapath: FSM state encoding,
// AXI RRESP encodings and the address low-bit width helper.
package redma_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_FLUSH  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // SLVERR and DECERR both have bit 1 set
    localparam int RRESP_ERR_BIT = 1;

    // Number of address bits that select a byte lane within one data beat
    function automatic int LOW_ALIGN_BITS(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/redma_if.sv
// Channel bundles used by the copy-engine datapath: AXI4 read-data channel
// and the write side of the inter-engine data FIFO.
interface AXI4_R #(
    parameter int DATA_WIDTH = 64
) ();
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport slave  (input  rvalid, rdata, rresp, rlast, output rready);
    modport master (output rvalid, rdata, rresp, rlast, input  rready);
endinterface

interface FIFO_WRITE #(
    parameter int DATA_WIDTH = 64
) ();
    logic                  write;
    logic [DATA_WIDTH-1:0] data;
    logic                  full;

    modport master (output write, data, input  full);
    modport slave  (input  write, data, output full);
endinterface

// File: rtl/r_engine_byte_realigner.sv
// byte_realigner: combinational 2W-to-W byte selector. Output lane j takes
// window byte W - shift + j, so shift = 0 returns the upper (current) half.
module byte_realigner #(
    parameter int W = 8
) (
    input  logic [2*W*8-1:0]      i_window,
    input  logic [$clog2(W)-1:0]  i_shift,
    output logic [W*8-1:0]        o_data
);

    // Barrel-select each output lane from the byte window
    always_comb begin
        o_data = '0;
        for (int j = 0; j < W; j++) begin
            o_data[j*8 +: 8] = i_window[(W - int'(i_shift) + j)*8 +: 8];
        end
    end

endmodule

// File: rtl/r_engine.sv
// r_engine: read-data stage of the copy datapath. Accepts the R beats of one
// transfer, shifts bytes from source lane alignment to destination lane
// alignment through a one-beat carry register, and pushes realigned beats
// into the data FIFO, adding a trailing flush beat when the destination
// spans more beats than the source.
// Optional feature macro: R_ENGINE_RESP_CHECK_EN (sticky rresp error flag).
module r_engine
    import redma_pkg::*;
#(
    parameter int AXI_DATA_WIDTH      = 64,
    parameter int INTERNAL_ADDR_WIDTH = 32,
    parameter int BTT_WIDTH           = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [INTERNAL_ADDR_WIDTH-1:0] src_addr,
    input  logic [INTERNAL_ADDR_WIDTH-1:0] dst_addr,
    input  logic [BTT_WIDTH-1:0]           btt,
    output logic                           idle,
    output logic                           done,
    output logic                           error,
    AXI4_R.slave                           r_chan,
    FIFO_WRITE.master                      data_fifo
);

    localparam int W  = AXI_DATA_WIDTH / 8;
    localparam int LW = LOW_ALIGN_BITS(AXI_DATA_WIDTH);
    // beat counters are wide enough for ceil((btt + W - 1) / W) without overflow
    localparam int CW = BTT_WIDTH - LW + 1;
    localparam int SW = BTT_WIDTH + 2;

    state_t                    r_state;
    logic [LW-1:0]             r_d;
    logic                      r_skip_pending;
    logic                      r_flush;
    logic [CW-1:0]             r_in_left;
    logic [AXI_DATA_WIDTH-1:0] r_prev;

    logic [LW-1:0]             w_so;
    logic [LW-1:0]             w_do;
    logic [LW-1:0]             w_d;
    logic [SW-1:0]             w_in_sum;
    logic [SW-1:0]             w_out_sum;
    logic [CW-1:0]             w_in_beats;
    logic [CW-1:0]             w_out_beats;
    logic                      w_skip;
    logic                      w_flush;
    logic                      w_start;
    logic                      w_accept;
    logic                      w_last_accept;
    logic [AXI_DATA_WIDTH-1:0] w_cur;
    logic [AXI_DATA_WIDTH-1:0] w_aligned;
    logic                      w_unused;

    assign w_so = src_addr[LW-1:0];
    assign w_do = dst_addr[LW-1:0];
    // lane shift wraps modulo W
    assign w_d  = w_do - w_so;

    assign w_in_sum    = SW'(btt) + SW'(w_so) + SW'(W - 1);
    assign w_out_sum   = SW'(btt) + SW'(w_do) + SW'(W - 1);
    assign w_in_beats  = CW'(w_in_sum >> LW);
    assign w_out_beats = CW'(w_out_sum >> LW);
    // when the destination offset is below the source offset the first
    // source beat only fills the carry register and produces no output
    assign w_skip      = (w_do < w_so);
    assign w_flush     = (w_out_beats > (w_in_beats - CW'(w_skip)));

    assign w_start       = start && (r_state == ST_IDLE);
    assign r_chan.rready = (r_state == ST_STREAM) && (r_skip_pending || !data_fifo.full);
    assign w_accept      = r_chan.rvalid && r_chan.rready;
    assign w_last_accept = w_accept && (r_in_left == CW'(1));

    // the flush beat is the carry register shifted against an all-zero beat
    assign w_cur = (r_state == ST_STREAM) ? r_chan.rdata : '0;

    byte_realigner #(
        .W (W)
    ) u_realigner (
        .i_window ({w_cur, r_prev}),
        .i_shift  (r_d),
        .o_data   (w_aligned)
    );

    assign data_fifo.data  = w_aligned;
    assign data_fifo.write = ((r_state == ST_STREAM) && w_accept && !r_skip_pending) ||
                             ((r_state == ST_FLUSH) && !data_fifo.full);

    assign idle = (r_state == ST_IDLE);
    assign done = (r_state == ST_DONE);

    // Control FSM, beat counter and carry register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= ST_IDLE;
            r_d            <= '0;
            r_skip_pending <= 1'b0;
            r_flush        <= 1'b0;
            r_in_left      <= '0;
            r_prev         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_d            <= w_d;
                        r_skip_pending <= w_skip;
                        r_flush        <= w_flush;
                        r_in_left      <= w_in_beats;
                        r_prev         <= '0;
                        r_state        <= (btt == '0) ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        r_prev         <= r_chan.rdata;
                        r_in_left      <= r_in_left - CW'(1);
                        r_skip_pending <= 1'b0;
                        if (w_last_accept) begin
                            r_state <= r_flush ? ST_FLUSH : ST_DONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!data_fifo.full) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef R_ENGINE_RESP_CHECK_EN
    logic r_error;

    // Sticky response error, cleared only by an accepted start
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_error <= 1'b0;
        end else if (w_start) begin
            r_error <= 1'b0;
        end else if (w_accept && r_chan.rresp[RRESP_ERR_BIT]) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    // rlast and the upper address bits carry no meaning for this stage
    assign w_unused = &{1'b0, r_chan.rlast, r_chan.rresp, src_addr, dst_addr};

endmodule

// File: tb/tb_r_engine.sv
// Testbench for r_engine with W = 8 bytes. Expected FIFO beats are computed
// from byte positions in the source stream and queued before each transfer;
// they are popped and compared as the DUT writes them.
module tb_r_engine;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] btt;
    logic        idle;
    logic        done;
    logic        error;

    AXI4_R     #(.DATA_WIDTH(64)) r_if ();
    FIFO_WRITE #(.DATA_WIDTH(64)) f_if ();

`ifdef R_ENGINE_RESP_CHECK_EN
    localparam bit RESP_EN = 1'b1;
`else
    localparam bit RESP_EN = 1'b0;
`endif

    r_engine #(
        .AXI_DATA_WIDTH      (64),
        .INTERNAL_ADDR_WIDTH (32),
        .BTT_WIDTH           (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .btt       (btt),
        .idle      (idle),
        .done      (done),
        .error     (error),
        .r_chan    (r_if),
        .data_fifo (f_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] beats [16];
    logic [63:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // Output beat k, lane j holds source-stream byte k*8 + j + so - do;
    // bytes before the first or past the last read beat are zero.
    function automatic logic [63:0] exp_beat(input int k, input int so, input int dof, input int nin);
        logic [63:0] r;
        logic [63:0] b;
        int          s;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            s = k*8 + j + so - dof;
            if (s >= 0 && s < nin*8) begin
                b = beats[s/8];
                r[j*8 +: 8] = b[(s%8)*8 +: 8];
            end
        end
        return r;
    endfunction

    task automatic run_xfer(input string name, input int so, input int dof, input int nbytes,
                            input int stall_at, input int gaps, input int err_beat, input bit restart);
        int          n_in;
        int          n_out;
        int          beat;
        int          writes;
        int          cyc;
        int          last_wr;
        int          stall_left;
        bit          done_seen;
        bit          stall;
        bit          exp_err;
        logic [63:0] exp_w;

        n_in  = (nbytes == 0) ? 0 : (nbytes + so + 7) / 8;
        n_out = (nbytes == 0) ? 0 : (nbytes + dof + 7) / 8;
        exp_err = RESP_EN && (err_beat >= 0) && (err_beat < n_in);
        for (int i = 0; i < 16; i++) beats[i] = {$urandom, $urandom};
        for (int k = 0; k < n_out; k++) exp_q.push_back(exp_beat(k, so, dof, n_in));

        src_addr = 32'h1000_0000 + 32'(so) + 32'(8 * $urandom_range(0, 15));
        dst_addr = 32'h2000_0040 + 32'(dof);
        btt      = 16'(nbytes);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;

        beat = 0; writes = 0; cyc = 0; last_wr = -1; stall_left = 5; done_seen = 1'b0;
        while (!done_seen && cyc < 300) begin
            stall        = (stall_at >= 0) && (writes == stall_at) && (stall_left > 0);
            f_if.full    = stall;
            r_if.rvalid  = (beat < n_in) && (gaps == 0 || $urandom_range(0, 3) != 0);
            r_if.rdata   = beats[beat];
            r_if.rresp   = (beat == err_beat) ? 2'b10 : 2'b00;
            r_if.rlast   = (beat == n_in - 1);
            if (restart && cyc == 1) begin
                start    = 1'b1;
                btt      = 16'd7;
                src_addr = 32'h3000_0005;
                dst_addr = 32'h4000_0002;
            end else begin
                start    = 1'b0;
            end
            @(negedge clk);
            if (stall) begin
                check_eq({name, "_stall_rready"}, 64'(r_if.rready), 64'd0);
                check_eq({name, "_stall_write"}, 64'(f_if.write), 64'd0);
                stall_left--;
            end
            if (f_if.write) begin
                if (exp_q.size() == 0) begin
                    check_eq({name, "_extra_write"}, 64'd1, 64'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check_eq({name, "_wdata"}, f_if.data, exp_w);
                end
                writes++;
                last_wr = cyc;
            end
            if (r_if.rvalid && r_if.rready) beat++;
            if (done) begin
                done_seen = 1'b1;
                if (n_out > 0) check_eq({name, "_done_latency"}, 64'(cyc), 64'(last_wr + 1));
                check_eq({name, "_done_rready"}, 64'(r_if.rready), 64'd0);
                check_eq({name, "_done_idle"}, 64'(idle), 64'd0);
                check_eq({name, "_error"}, 64'(error), 64'(exp_err));
            end
            @(posedge clk); #1;
            cyc++;
        end
        start       = 1'b0;
        r_if.rvalid = 1'b0;
        f_if.full   = 1'b0;
        check_eq({name, "_timeout"}, 64'(done_seen), 64'd1);
        @(negedge clk);
        check_eq({name, "_idle_after"}, 64'(idle), 64'd1);
        check_eq({name, "_nwrites"}, 64'(writes), 64'(n_out));
        check_eq({name, "_nreads"}, 64'(beat), 64'(n_in));
        check_eq({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        src_addr    = '0;
        dst_addr    = '0;
        btt         = '0;
        r_if.rvalid = 1'b0;
        r_if.rdata  = '0;
        r_if.rresp  = 2'b00;
        r_if.rlast  = 1'b0;
        f_if.full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check_eq("rst_idle",   64'(idle),        64'd1);
        check_eq("rst_done",   64'(done),        64'd0);
        check_eq("rst_error",  64'(error),       64'd0);
        check_eq("rst_rready", 64'(r_if.rready), 64'd0);
        check_eq("rst_write",  64'(f_if.write),  64'd0);
        @(posedge clk); #1;

        run_xfer("aligned",   0, 0, 32, -1, 0, -1, 1'b0);
        run_xfer("so3_do5",   3, 5, 10, -1, 0, -1, 1'b0);
        run_xfer("so5_do1",   5, 1, 10, -1, 0, -1, 1'b0);
        run_xfer("so0_do6",   0, 6,  8, -1, 0, -1, 1'b0);
        run_xfer("stall",     0, 0, 32,  2, 0, -1, 1'b0);
        run_xfer("gaps",      2, 7, 29, -1, 1, -1, 1'b1);
        run_xfer("btt0",      3, 4,  0, -1, 0, -1, 1'b0);
        run_xfer("rresp_err", 0, 0, 32, -1, 0,  1, 1'b0);
        run_xfer("err_clear", 1, 0, 20, -1, 1, -1, 1'b0);

        // reset in the middle of a transfer abandons it
        src_addr = 32'h1000_0000;
        dst_addr = 32'h2000_0000;
        btt      = 16'd32;
        start    = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        r_if.rvalid = 1'b1;
        r_if.rdata  = 64'h0123_4567_89ab_cdef;
        @(negedge clk);
        check_eq("midrst_rready_before", 64'(r_if.rready), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check_eq("midrst_idle",   64'(idle),        64'd1);
        check_eq("midrst_rready", 64'(r_if.rready), 64'd0);
        check_eq("midrst_write",  64'(f_if.write),  64'd0);
        @(posedge clk); #1;
        r_if.rvalid = 1'b0;

        run_xfer("after_rst", 4, 4, 16, -1, 0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
